// File: rtl/jtframe_mcu_pkg.sv
// jtframe_mcu_pkg: shared types and constants for the MCU bus fabric
package jtframe_mcu_pkg;
  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;
  typedef enum logic [3:0] {
    SEL_NONE = 4'b0000,
    SEL_IRAM = 4'b0001,
    SEL_SH   = 4'b0010,
    SEL_PORT = 4'b0100,
    SEL_ROM  = 4'b1000
  } sel_t;
  localparam logic [7:0] UNMAPPED_DATA = 8'hFF;
endpackage

// File: rtl/jtframe_dual_ram.sv
// jtframe_dual_ram: true dual-port RAM with registered reads, port 1 wins on collision
module jtframe_dual_ram #(
  parameter int DW = 8,
  parameter int AW = 9
)(
  input  logic          clk,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] data0,
  input  logic          we0,
  output logic [DW-1:0] q0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] data1,
  input  logic          we1,
  output logic [DW-1:0] q1
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    q0 <= mem[addr0];
    q1 <= mem[addr1];
    if (we0) mem[addr0] <= data0;
    if (we1) mem[addr1] <= data1;
  end
endmodule

// File: rtl/jtframe_mcu_wbuf.sv
// jtframe_mcu_wbuf: one-deep main-side shared RAM write buffer, commits while the MCU is halted
module jtframe_mcu_wbuf #(
  parameter int AW = 9
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          halted,
  input  logic [AW-1:0] addr,
  input  logic          cs,
  input  logic          wrn,
  input  logic [7:0]    din,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [7:0]    wdata,
  output logic          busy
);
  logic          wr_l, full, stb, commit, load;
  logic [AW-1:0] baddr;
  logic [7:0]    bdata;
  always_comb begin
    stb    = cs & ~wrn & ~wr_l & ~rst;
    commit = full & halted;
    load   = stb & (~halted | full);
    we     = commit | (stb & halted);
    waddr  = full ? baddr : addr;
    wdata  = full ? bdata : din;
    busy   = full;
  end
  always_ff @(posedge clk) begin
    wr_l <= ~rst & cs & ~wrn;
    full <= ~rst & (load | (full & ~commit));
    if (load) begin
      baddr <= addr;
      bdata <= din;
    end
  end
endmodule

// File: rtl/jtframe_ram.sv
// jtframe_ram: single-port RAM with registered read
module jtframe_ram #(
  parameter int DW = 8,
  parameter int AW = 8
)(
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  input  logic          we,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    q <= mem[addr];
    if (we) mem[addr] <= data;
  end
endmodule

// File: rtl/jtframe_mcu_bus.sv
// jtframe_mcu_bus: 6801 MCU bus fabric; define JTFRAME_MCU_WAIT_TIMEOUT_EN for the ROM wait timeout
module jtframe_mcu_bus
  import jtframe_mcu_pkg::*;
#(
  parameter int          SHW       = 9,
  parameter int          IRAMW     = 8,
  parameter int          ROMW      = 14,
  parameter int          NOUT      = 2,
  parameter logic [15:0] OUT_ADDR  = 16'h0017,
  parameter logic [15:0] IRAM_BASE = 16'h0040,
  parameter logic [3:0]  SH_NIB    = 4'h8,
  parameter int          TOW       = 10
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  output logic              cpu_cen,
  input  logic [15:0]       mcu_addr,
  input  logic              mcu_vma,
  input  logic              mcu_rnw,
  input  logic [7:0]        mcu_dout,
  output logic [7:0]        mcu_din,
  input  logic              mcu_halted,
  input  logic [SHW-1:0]    main_addr,
  input  logic              main_cs,
  input  logic              main_wrn,
  input  logic [7:0]        main_dout,
  output logic [7:0]        main_din,
  output logic              main_wbusy,
  input  logic              nmi_set,
  output logic              nmi,
  output logic [8*NOUT-1:0] port_out,
  output logic [ROMW-1:0]   rom_addr,
  output logic              rom_cs,
  input  logic [7:0]        rom_data,
  input  logic              rom_ok
`ifdef JTFRAME_MCU_WAIT_TIMEOUT_EN
  ,output logic             rom_timeout
`endif
);
  if (NOUT < 1 || NOUT > 8 || TOW < 1) begin : g_bad_param
    $error("jtframe_mcu_bus: bad NOUT/TOW");
  end
  state_t         st, st_nx;
  sel_t           sel, sel_q;
  logic [16:0]    a17;
  logic [15:0]    pofs;
  logic           in_iram, in_sh, in_port, in_rom, miss, wr, tmo, nmi_l;
  logic [7:0]     port_q [NOUT];
  logic [7:0]     port_rd, din_q, iram_q, sh_q;
  logic           bwe;
  logic [SHW-1:0] baddr;
  logic [7:0]     bdata;
  always_comb begin
    a17     = {1'b0, mcu_addr};
    pofs    = mcu_addr - OUT_ADDR;
    in_iram = a17 >= {1'b0, IRAM_BASE} && a17 < {1'b0, IRAM_BASE} + 17'(1 << IRAMW);
    in_sh   = mcu_addr[15:12] == SH_NIB;
    in_port = a17 >= {1'b0, OUT_ADDR} && a17 < {1'b0, OUT_ADDR} + 17'(NOUT);
    in_rom  = &mcu_addr[15:14];
    sel     = !mcu_vma ? SEL_NONE : in_iram ? SEL_IRAM : in_sh ? SEL_SH :
              in_port ? SEL_PORT : in_rom ? SEL_ROM : SEL_NONE;
    rom_cs  = sel == SEL_ROM;
    rom_addr = mcu_addr[ROMW-1:0];
    miss    = rom_cs & ~rom_ok;
    cpu_cen = cen & ~miss & (st == ST_RUN);
    wr      = ~mcu_rnw & cpu_cen;
    st_nx   = st == ST_RUN ? (miss ? ST_WAIT : ST_RUN) : (rom_ok | tmo) ? ST_RUN : ST_WAIT;
    port_rd = '0;
    for (int i = 0; i < NOUT; i++) port_rd = pofs == 16'(i) ? port_q[i] : port_rd;
    mcu_din = sel_q == SEL_IRAM ? iram_q : sel_q == SEL_SH ? sh_q : din_q;
  end
  always_ff @(posedge clk) begin
    st    <= rst ? ST_RUN : st_nx;
    sel_q <= rst ? SEL_NONE : sel;
    din_q <= rst ? 8'h00 : sel == SEL_PORT ? port_rd : sel == SEL_ROM ? rom_data : UNMAPPED_DATA;
    nmi_l <= nmi_set;
    nmi   <= ~rst & port_q[0][0] & (nmi | (nmi_set & ~nmi_l));
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NOUT; i++)
      if (rst) port_q[i] <= 8'h00;
      else if (sel == SEL_PORT && wr && pofs == 16'(i)) port_q[i] <= mcu_dout;
  for (genvar k = 0; k < NOUT; k++) begin : g_port
    assign port_out[8*k +: 8] = port_q[k];
  end
`ifdef JTFRAME_MCU_WAIT_TIMEOUT_EN
  logic [TOW-1:0] cnt;
  assign tmo = &cnt;
  always_ff @(posedge clk) begin
    cnt         <= (rst || st == ST_RUN) ? '0 : cnt + 1'b1;
    rom_timeout <= ~rst & (rom_timeout | (st == ST_WAIT & tmo));
  end
`ifdef SIMULATION
  always @(posedge clk)
    if (!rst && st == ST_WAIT && tmo) $display("jtframe_mcu_bus: ROM wait timeout at %h", mcu_addr);
`endif
`else
  assign tmo = 1'b0;
`endif
  jtframe_ram #(.DW(8), .AW(IRAMW)) u_iram (
    .clk  (clk),
    .addr (mcu_addr[IRAMW-1:0] - IRAM_BASE[IRAMW-1:0]),
    .data (mcu_dout),
    .we   (sel == SEL_IRAM && wr),
    .q    (iram_q)
  );
  jtframe_mcu_wbuf #(.AW(SHW)) u_wbuf (
    .clk    (clk),
    .rst    (rst),
    .halted (mcu_halted),
    .addr   (main_addr),
    .cs     (main_cs),
    .wrn    (main_wrn),
    .din    (main_dout),
    .we     (bwe),
    .waddr  (baddr),
    .wdata  (bdata),
    .busy   (main_wbusy)
  );
  jtframe_dual_ram #(.DW(8), .AW(SHW)) u_shared (
    .clk   (clk),
    .addr0 (mcu_addr[SHW-1:0]),
    .data0 (mcu_dout),
    .we0   (sel == SEL_SH && wr),
    .q0    (sh_q),
    .addr1 (bwe ? baddr : main_addr),
    .data1 (bdata),
    .we1   (bwe),
    .q1    (main_din)
  );
endmodule
